// File: rtl/cpu_v1_pkg.sv
// Shared definitions for the Simple CPU v1 control path: opcode fields, ALU codes,
// sequencer state encoding and B-operand mux selects.
package cpu_v1_pkg;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int IMM_BIT = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // ALU codes coincide with the opcode field; LD is the pass-B operation.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_IDLE  = 3'b000;

  localparam logic [2:0] ST_FETCH_OP  = 3'd0;
  localparam logic [2:0] ST_FETCH_ARG = 3'd1;
  localparam logic [2:0] ST_MEM_RD    = 3'd2;
  localparam logic [2:0] ST_EXEC_IMM  = 3'd3;
  localparam logic [2:0] ST_MEM_WR    = 3'd4;
  localparam logic [2:0] ST_JUMP      = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;
  localparam logic [2:0] ST_FAULT     = 3'd7;

  localparam logic MUXB_MEM = 1'b0;
  localparam logic MUXB_IR  = 1'b1;

  typedef struct packed {
    logic       muxb;
    logic       ir_ld;
    logic [2:0] alu_op;
    logic       acc_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       halted;
    logic       fault;
  } ctrl_t;

  function automatic logic [2:0] state_after_arg(input logic [2:0] op, input logic imm);
    logic [2:0] nxt;
    if (op == OP_ST)       nxt = ST_MEM_WR;
    else if (op == OP_JMP) nxt = ST_JUMP;
    else if (imm)          nxt = ST_EXEC_IMM;
    else                   nxt = ST_MEM_RD;
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_ctrl_timeout.sv
// Memory-handshake wait counter; expired fires in the request cycle that would
// make the count reach TIMEOUT_CYC.
module cpu_ctrl_timeout #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for Simple CPU v1 (opcode fetch, operand fetch, execute).
// Optional memory-ack timeout fault enabled by defining CPU_CTRL_TIMEOUT_EN.
module cpu_ctrl_seq
  import cpu_v1_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic       zero,
  output logic       muxb,
  output logic       ir_ld,
  output logic [2:0] alu_op,
  output logic       acc_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       halted,
  output logic       fault
);

  logic [2:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       imm_q, imm_d;
  logic       tmo_expired;
  ctrl_t      ctl;
  ctrl_t      ctl_out;

  always_comb begin
    ctl      = '0;
    ctl.muxb = MUXB_MEM;
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    case (state_q)
      ST_FETCH_OP: begin
        ctl.mem_req = 1'b1;
        if (mem_ack) begin
          op_d       = mem_rdata[OP_MSB:OP_LSB];
          imm_d      = mem_rdata[IMM_BIT];
          ctl.pc_inc = 1'b1;
          state_d    = (mem_rdata[OP_MSB:OP_LSB] == OP_HLT) ? ST_HALT : ST_FETCH_ARG;
        end
      end
      ST_FETCH_ARG: begin
        ctl.mem_req = 1'b1;
        if (mem_ack) begin
          ctl.ir_ld  = 1'b1;
          ctl.pc_inc = 1'b1;
          state_d    = state_after_arg(op_q, imm_q);
        end
      end
      ST_MEM_RD: begin
        ctl.mem_req  = 1'b1;
        ctl.addr_sel = 1'b1;
        ctl.alu_op   = op_q;
        if (mem_ack) begin
          ctl.acc_ld = 1'b1;
          state_d    = ST_FETCH_OP;
        end
      end
      ST_EXEC_IMM: begin
        ctl.muxb   = MUXB_IR;
        ctl.alu_op = op_q;
        ctl.acc_ld = 1'b1;
        state_d    = ST_FETCH_OP;
      end
      ST_MEM_WR: begin
        ctl.mem_req  = 1'b1;
        ctl.mem_we   = 1'b1;
        ctl.addr_sel = 1'b1;
        if (mem_ack) state_d = ST_FETCH_OP;
      end
      ST_JUMP: begin
        ctl.pc_ld = 1'b1;
        state_d   = ST_FETCH_OP;
      end
      ST_HALT:  ctl.halted = 1'b1;
      ST_FAULT: ctl.fault  = 1'b1;
      default:  state_d    = ST_FETCH_OP;
    endcase
    // A stalled request that runs out of patience abandons the instruction.
    if (ctl.mem_req && !mem_ack && tmo_expired) state_d = ST_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH_OP;
      op_q    <= ALU_IDLE;
      imm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
    end
  end

`ifdef CPU_CTRL_TIMEOUT_EN
  cpu_ctrl_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .en      (ctl.mem_req && !mem_ack),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Gating with rst_n makes every strobe, mem_req included, drop the instant reset asserts.
  assign ctl_out = rst_n ? ctl : '0;

  assign muxb     = ctl_out.muxb;
  assign ir_ld    = ctl_out.ir_ld;
  assign alu_op   = ctl_out.alu_op;
  assign acc_ld   = ctl_out.acc_ld;
  assign pc_inc   = ctl_out.pc_inc;
  assign pc_ld    = ctl_out.pc_ld;
  assign mem_req  = ctl_out.mem_req;
  assign mem_we   = ctl_out.mem_we;
  assign addr_sel = ctl_out.addr_sel;
  assign halted   = ctl_out.halted;
`ifdef CPU_CTRL_TIMEOUT_EN
  assign fault    = ctl_out.fault;
`else
  assign fault    = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = ^{zero, mem_rdata[3:0], TIMEOUT_CYC[0]};

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: instruction-level trace model plus literal pins.
module tb_cpu_ctrl_seq;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       zero;
  logic       muxb, ir_ld, acc_ld, pc_inc, pc_ld, mem_req, mem_we, addr_sel, halted, fault;
  logic [2:0] alu_op;

  cpu_ctrl_seq #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .zero(zero),
    .muxb(muxb), .ir_ld(ir_ld), .alu_op(alu_op), .acc_ld(acc_ld), .pc_inc(pc_inc),
    .pc_ld(pc_ld), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // {muxb, ir_ld, alu_op[2:0], acc_ld, pc_inc, pc_ld, mem_req, mem_we, addr_sel, halted, fault}
  typedef struct {
    logic        ack;
    logic [7:0]  rd;
    logic [12:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   c_inc, c_acc, c_pcld, c_req, c_we, c_irld, c_flt, c_hlt;

  function automatic logic [12:0] actual();
    return {muxb, ir_ld, alu_op, acc_ld, pc_inc, pc_ld, mem_req, mem_we, addr_sel, halted, fault};
  endfunction

  function automatic logic [12:0] ov(input logic mb, input logic ir, input logic [2:0] alu,
                                     input logic acc, input logic inc, input logic ld,
                                     input logic req, input logic we, input logic asel,
                                     input logic hlt, input logic flt);
    return {mb, ir, alu, acc, inc, ld, req, we, asel, hlt, flt};
  endfunction

  task automatic push(input logic ack, input logic [7:0] rd, input logic [12:0] e);
    cyc_t c;
    c.ack = ack; c.rd = rd; c.exp = e;
    q.push_back(c);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected per-cycle trace of one instruction, built from the instruction's semantics.
  task automatic instr(input logic [7:0] opc, input logic [7:0] arg,
                       input int w_op, input int w_arg, input int w_mem);
    logic [2:0] op;
    logic       imm;
    op  = opc[7:5];
    imm = opc[4];
    repeat (w_op) push(1'b0, 8'h00, ov(0,0,3'd0,0,0,0,1,0,0,0,0));
    push(1'b1, opc, ov(0,0,3'd0,0,1,0,1,0,0,0,0));
    if (op == 3'b111) return;
    repeat (w_arg) push(1'b0, 8'h00, ov(0,0,3'd0,0,0,0,1,0,0,0,0));
    push(1'b1, arg, ov(0,1,3'd0,0,1,0,1,0,0,0,0));
    if (op == 3'b101) begin
      repeat (w_mem) push(1'b0, 8'h00, ov(0,0,3'd0,0,0,0,1,1,1,0,0));
      push(1'b1, 8'h00, ov(0,0,3'd0,0,0,0,1,1,1,0,0));
    end else if (op == 3'b110) begin
      push(1'b1, 8'hFF, ov(0,0,3'd0,0,0,1,0,0,0,0,0));
    end else if (imm) begin
      push(1'b1, 8'hFF, ov(1,0,op,1,0,0,0,0,0,0,0));
    end else begin
      repeat (w_mem) push(1'b0, 8'h00, ov(0,0,op,0,0,0,1,0,1,0,0));
      push(1'b1, 8'h5A, ov(0,0,op,1,0,0,1,0,1,0,0));
    end
  endtask

  // Entered and left at posedge+1; drives inputs, compares at negedge.
  task automatic run(input string name, input int limit);
    int n;
    logic [12:0] a;
    n = (limit < q.size()) ? limit : q.size();
    c_inc = 0; c_acc = 0; c_pcld = 0; c_req = 0; c_we = 0; c_irld = 0; c_flt = 0; c_hlt = 0;
    for (int i = 0; i < n; i++) begin
      mem_ack   = q[i].ack;
      mem_rdata = q[i].rd;
      @(negedge clk);
      a = actual();
      n_chk++;
      if (a !== q[i].exp) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %b expected %b", name, i, a, q[i].exp);
      end
      c_inc += int'(pc_inc); c_acc += int'(acc_ld); c_pcld += int'(pc_ld);
      c_req += int'(mem_req); c_we += int'(mem_we); c_irld += int'(ir_ld);
      c_flt += int'(fault); c_hlt += int'(halted);
      @(posedge clk); #1;
    end
    q.delete();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  endtask

  task automatic reset_release(input string name);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check({name, "_req"}, int'(mem_req), 1);
    check({name, "_asel"}, int'(addr_sel), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hE0; zero = 1'b0;
    #12;
    check("in_reset_outputs", int'(actual()), 0);
    mem_ack = 1'b0;
    reset_release("por");

    instr(8'h10, 8'h05, 0, 0, 0);
    len = q.size();
    check("add_len", len, 3);
    check("add_exec_vec", int'(q[2].exp), 13'h1080);
    run("add_imm", len);
    check("add_pc_inc", c_inc, 2);
    check("add_ir_ld", c_irld, 1);
    check("add_acc_ld", c_acc, 1);

    instr(8'h20, 8'h3C, 0, 0, 2);
    len = q.size();
    check("sub_len", len, 5);
    run("sub_mem", len);
    check("sub_acc_ld", c_acc, 1);
    check("sub_req", c_req, 5);

    instr(8'hA0, 8'h40, 0, 0, 1);
    len = q.size();
    run("st", len);
    check("st_len", len, 4);
    check("st_we", c_we, 2);
    check("st_acc", c_acc, 0);

    instr(8'hC0, 8'h08, 0, 0, 0);
    len = q.size();
    run("jmp", len);
    check("jmp_len", len, 3);
    check("jmp_pc_ld", c_pcld, 1);
    check("jmp_acc", c_acc, 0);

    instr(8'h90, 8'h77, 1, 2, 0);
    len = q.size();
    check("ld_len", len, 6);
    run("ld_imm_waits", len);
    instr(8'h60, 8'h12, 0, 0, 0);
    instr(8'h5F, 8'h0F, 0, 0, 0);
    instr(8'hB0, 8'h21, 0, 0, 0);
    instr(8'hD0, 8'h30, 0, 0, 0);
    instr(8'h30, 8'h44, 2, 1, 3);
    run("mix", q.size());
    check("mix_acc", c_acc, 3);
    check("mix_pc_ld", c_pcld, 1);

    // Reset in the middle of a stalled MEM_RD.
    instr(8'h20, 8'h3C, 0, 0, 5);
    run("sub_partial", 4);
    #1;
    check("mid_rd_req", int'(mem_req), 1);
    check("mid_rd_asel", int'(addr_sel), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(actual()), 0);
    reset_release("mid");

    instr(8'hE0, 8'h00, 0, 0, 0);
    repeat (50) push(1'b1, 8'h10, ov(0,0,3'd0,0,0,0,0,0,0,1,0));
    len = q.size();
    run("hlt", len);
    check("hlt_len", len, 51);
    check("hlt_req", c_req, 1);
    check("hlt_pc_inc", c_inc, 1);
    check("hlt_halted", c_hlt, 50);

    rst_n = 1'b0;
    reset_release("post_hlt");

    for (int i = 0; i < 40; i++) begin
`ifdef CPU_CTRL_TIMEOUT_EN
      if (i < TMO) push(1'b0, 8'h00, ov(0,0,3'd0,0,0,0,1,0,0,0,0));
      else         push(1'b0, 8'h00, ov(0,0,3'd0,0,0,0,0,0,0,0,1));
`else
      push(1'b0, 8'h00, ov(0,0,3'd0,0,0,0,1,0,0,0,0));
`endif
    end
    run("stall", 40);
`ifdef CPU_CTRL_TIMEOUT_EN
    check("stall_req", c_req, 16);
    check("stall_fault", c_flt, 24);
`else
    check("stall_req", c_req, 40);
    check("stall_fault", c_flt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Multi-cycle control sequencer for the Simple CPU v1.
- Sits directly upstream of the B-operand mux and the ALU/accumulator datapath.
- Fetches a two-byte instruction (opcode byte, then operand byte into IR) and drives the datapath strobes.
- Strobes driven: B-operand select, IR load, ALU op, accumulator load, PC increment/load, memory request/write.

Parameters:
TIMEOUT_CYC, 16, cycles to wait for mem_ack before fault; used only when CPU_CTRL_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
mem_ack  input  1  memory handshake acknowledge; mem_rdata valid in the same cycle
mem_rdata  input  8  memory read data (opcode byte during fetch)
zero  input  1  accumulator-zero flag; reserved, no effect in v1
muxb  output  1  B-operand select: 0 = memory data, 1 = IR
ir_ld  output  1  load IR from mem_rdata
alu_op  output  3  ALU operation code
acc_ld  output  1  load accumulator from ALU result
pc_inc  output  1  increment PC
pc_ld  output  1  load PC from IR
mem_req  output  1  memory request
mem_we  output  1  memory write (valid with mem_req)
addr_sel  output  1  address source: 0 = PC, 1 = IR
halted  output  1  CPU halted
fault  output  1  memory timeout fault (constant 0 without the macro)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - State goes to FETCH_OP and the opcode register to 0.
  - All outputs are 0 while rst_n is low.
  - Reset mid-transaction aborts immediately: mem_req drops asynchronously.
  - First cycle after release: FETCH_OP with mem_req=1.
- Opcode byte fields:
  - [7:5] op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LD, 101 ST, 110 JMP, 111 HLT.
  - [4] imm: 1 = operand byte is the value; 0 = operand byte is an address.
  - [3:0] ignored.
- Handshake:
  - mem_req is held high until mem_ack is sampled high. The ack cycle completes the transfer.
  - Zero-wait acks (ack in the first request cycle) are legal.
  - mem_ack is ignored when mem_req=0.
- Outputs are decoded from the state register and opcode register. Strobes qualified by mem_ack are Mealy.
- States and outputs:
  - FETCH_OP: mem_req=1, addr_sel=0. On ack: latch opcode, pc_inc=1. If op=HLT go to HALT, else FETCH_ARG.
  - FETCH_ARG: mem_req=1, addr_sel=0. On ack: ir_ld=1, pc_inc=1. Next state:
    - ST goes to MEM_WR.
    - JMP goes to JUMP.
    - ALU/LD with imm=1 goes to EXEC_IMM.
    - ALU/LD with imm=0 goes to MEM_RD.
  - MEM_RD: mem_req=1, addr_sel=1, muxb=0, alu_op=op. On ack: acc_ld=1, go to FETCH_OP.
  - EXEC_IMM: muxb=1, alu_op=op, acc_ld=1 for one cycle, then FETCH_OP.
  - MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On ack: go to FETCH_OP. The imm bit is ignored.
  - JUMP: pc_ld=1 for one cycle, then FETCH_OP. The imm bit is ignored.
  - HALT: halted=1, all strobes 0. Exit only via reset.
  - FAULT (macro only): fault=1, all strobes 0. Exit only via reset.
- Defaults:
  - muxb=0 in every state except EXEC_IMM.
  - alu_op=op[2:0] in MEM_RD and EXEC_IMM, else 000.
  - LD (100) is the ALU pass-B operation.
- Latency with zero-wait memory: every non-HLT instruction takes 3 cycles. Each wait cycle adds 1.

Optional Feature:
- Macro CPU_CTRL_TIMEOUT_EN.
- Defined: a wait counter clears when entering any mem_req state and counts each cycle mem_req=1 and mem_ack=0. On reaching TIMEOUT_CYC go to FAULT, drop mem_req, assert fault.
- Undefined: no counter; the sequencer waits forever and fault is tied to 0.

Decomposition:
- Package cpu_v1_pkg holds:
  - opcode constants and field positions (OP_MSB/LSB, IMM_BIT);
  - ALU op codes;
  - state encoding constants;
  - muxb select values (MUXB_MEM=0, MUXB_IR=1).
- One sub-module, cpu_ctrl_timeout: wait counter with clr/en inputs and an expired output. Instantiated only under the macro.

Test Plan:
- Reset: rst_n low mid MEM_RD with mem_req=1 -> all outputs 0 immediately; one cycle after release mem_req=1, addr_sel=0.
- ADD imm, zero-wait: rdata 0x10 then 0x05 -> cycle 2 ir_ld=1; cycle 3 muxb=1, alu_op=000, acc_ld=1; cycle 4 back to FETCH_OP; pc_inc pulsed exactly twice.
- SUB mem, 2 wait cycles on the operand read: opcode 0x20, addr 0x3C -> MEM_RD holds mem_req=1, addr_sel=1, muxb=0 for 3 cycles; acc_ld=1 only in the ack cycle.
- ST and JMP: 0xA0/0x40 -> mem_we=1 with addr_sel=1 until ack, muxb=0 throughout; 0xC0/0x08 -> pc_ld=1 for exactly one cycle, acc_ld never asserted.
- HLT: 0xE0 -> halted=1 after the opcode ack, no pc_inc for the arg, no mem_req for 50 cycles even with mem_ack forced high.
- With CPU_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16: withhold mem_ack in FETCH_OP -> fault=1 after 16 request cycles and mem_req=0; without the macro, mem_req stays high.
